// File: rtl/tennis_scoreboard.sv
// Tennis game/match scoring driven by single-cycle point pulses, with the
// score time-multiplexed onto an 8-digit active-low seven-segment display.
module tennis_scoreboard #(
    parameter int REFRESH_DIV  = 100000,
    parameter int GAMES_TO_WIN = 6
) (
    input  logic       clk,
    input  logic       reset_clk,
    input  logic       point_p1,
    input  logic       point_p2,
    output logic [7:0] AN,
    output logic [6:0] C,
    output logic [2:0] p1_pts,
    output logic [2:0] p2_pts,
    output logic [3:0] p1_games,
    output logic [3:0] p2_games,
    output logic       game_over,
    output logic       winner
);

    localparam int              CNT_W        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(REFRESH_DIV - 1);
    localparam logic [3:0]      GAMES_TARGET = 4'(GAMES_TO_WIN);

    localparam logic [2:0] PTS_0  = 3'd0;
    localparam logic [2:0] PTS_15 = 3'd1;
    localparam logic [2:0] PTS_30 = 3'd2;
    localparam logic [2:0] PTS_40 = 3'd3;
    localparam logic [2:0] PTS_AD = 3'd4;

    localparam logic [3:0] GLYPH_A     = 4'd10;
    localparam logic [3:0] GLYPH_D     = 4'd11;
    localparam logic [3:0] GLYPH_BLANK = 4'd15;

    function automatic logic [6:0] seg_encode(input logic [3:0] glyph);
        logic [6:0] seg;
        case (glyph)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            GLYPH_A: seg = 7'h08;
            GLYPH_D: seg = 7'h21;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    function automatic logic [3:0] pts_tens(input logic [2:0] code);
        logic [3:0] glyph;
        case (code)
            PTS_0:   glyph = 4'd0;
            PTS_15:  glyph = 4'd1;
            PTS_30:  glyph = 4'd3;
            PTS_40:  glyph = 4'd4;
            PTS_AD:  glyph = GLYPH_A;
            default: glyph = GLYPH_BLANK;
        endcase
        return glyph;
    endfunction

    function automatic logic [3:0] pts_units(input logic [2:0] code);
        logic [3:0] glyph;
        case (code)
            PTS_0:   glyph = 4'd0;
            PTS_15:  glyph = 4'd5;
            PTS_30:  glyph = 4'd0;
            PTS_40:  glyph = 4'd0;
            PTS_AD:  glyph = GLYPH_D;
            default: glyph = GLYPH_BLANK;
        endcase
        return glyph;
    endfunction

    function automatic logic [3:0] games_glyph(input logic [3:0] games);
        logic [3:0] glyph;
        if (games <= 4'd9) begin
            glyph = games;
        end else begin
            glyph = GLYPH_BLANK;
        end
        return glyph;
    endfunction

    logic [2:0]       p1_pts_r, p2_pts_r;
    logic [3:0]       p1_games_r, p2_games_r;
    logic             game_over_r, winner_r;
    logic [CNT_W-1:0] refresh_cnt_r;
    logic [2:0]       digit_idx_r;
    logic [7:0]       an_r;
    logic [6:0]       c_r;

    logic [2:0]       p1_pts_nxt_s, p2_pts_nxt_s;
    logic [3:0]       p1_games_nxt_s, p2_games_nxt_s;
    logic             game_over_nxt_s, winner_nxt_s;
    logic [CNT_W-1:0] refresh_cnt_nxt_s;
    logic [2:0]       digit_idx_nxt_s;
    logic [7:0]       an_nxt_s;
    logic [6:0]       c_nxt_s;
    logic [3:0]       glyph_s;

    logic             point_event_s;
    logic             scorer_is_p2_s;
    logic [2:0]       scorer_pts_s, other_pts_s;
    logic [2:0]       scorer_pts_nxt_s, other_pts_nxt_s;
    logic             game_won_s;
    logic [3:0]       scorer_games_inc_s;

    // Rally outcome from the scorer's point of view; P1 and P2 share one rule set.
    always_comb begin
        point_event_s    = (point_p1 ^ point_p2) & ~game_over_r;
        scorer_is_p2_s   = point_p2;
        scorer_pts_s     = scorer_is_p2_s ? p2_pts_r : p1_pts_r;
        other_pts_s      = scorer_is_p2_s ? p1_pts_r : p2_pts_r;
        scorer_pts_nxt_s = scorer_pts_s;
        other_pts_nxt_s  = other_pts_s;
        game_won_s       = 1'b0;
        if (other_pts_s == PTS_AD) begin
            other_pts_nxt_s = PTS_40;
        end else if (scorer_pts_s < PTS_40) begin
            scorer_pts_nxt_s = scorer_pts_s + 3'd1;
        end else if ((scorer_pts_s == PTS_40) && (other_pts_s == PTS_40)) begin
            scorer_pts_nxt_s = PTS_AD;
        end else begin
            game_won_s = 1'b1;
        end
        scorer_games_inc_s = (scorer_is_p2_s ? p2_games_r : p1_games_r) + 4'd1;
    end

    // Next match state: apply the rally outcome, or hold on ignored/idle cycles.
    always_comb begin
        p1_pts_nxt_s    = p1_pts_r;
        p2_pts_nxt_s    = p2_pts_r;
        p1_games_nxt_s  = p1_games_r;
        p2_games_nxt_s  = p2_games_r;
        game_over_nxt_s = game_over_r;
        winner_nxt_s    = winner_r;
        if (point_event_s) begin
            if (game_won_s) begin
                p1_pts_nxt_s = PTS_0;
                p2_pts_nxt_s = PTS_0;
                if (scorer_is_p2_s) begin
                    p2_games_nxt_s = scorer_games_inc_s;
                end else begin
                    p1_games_nxt_s = scorer_games_inc_s;
                end
                if (scorer_games_inc_s == GAMES_TARGET) begin
                    game_over_nxt_s = 1'b1;
                    winner_nxt_s    = scorer_is_p2_s;
                end else begin
                    game_over_nxt_s = game_over_r;
                end
            end else if (scorer_is_p2_s) begin
                p2_pts_nxt_s = scorer_pts_nxt_s;
                p1_pts_nxt_s = other_pts_nxt_s;
            end else begin
                p1_pts_nxt_s = scorer_pts_nxt_s;
                p2_pts_nxt_s = other_pts_nxt_s;
            end
        end else begin
            p1_pts_nxt_s = p1_pts_r;
        end
    end

    // Scan timing: each digit stays lit for REFRESH_DIV cycles.
    always_comb begin
        if (refresh_cnt_r == CNT_MAX) begin
            refresh_cnt_nxt_s = '0;
            digit_idx_nxt_s   = digit_idx_r + 3'd1;
        end else begin
            refresh_cnt_nxt_s = refresh_cnt_r + CNT_W'(1);
            digit_idx_nxt_s   = digit_idx_r;
        end
    end

    // Glyph for the digit currently being scanned.
    always_comb begin
        case (digit_idx_r)
            3'd7:    glyph_s = pts_tens(p1_pts_r);
            3'd6:    glyph_s = pts_units(p1_pts_r);
            3'd5:    glyph_s = GLYPH_BLANK;
            3'd4:    glyph_s = games_glyph(p1_games_r);
            3'd3:    glyph_s = games_glyph(p2_games_r);
            3'd2:    glyph_s = GLYPH_BLANK;
            3'd1:    glyph_s = pts_tens(p2_pts_r);
            3'd0:    glyph_s = pts_units(p2_pts_r);
            default: glyph_s = GLYPH_BLANK;
        endcase
        an_nxt_s = ~(8'b0000_0001 << digit_idx_r);
        c_nxt_s  = seg_encode(glyph_s);
    end

    // State and display registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset_clk) begin
            p1_pts_r      <= PTS_0;
            p2_pts_r      <= PTS_0;
            p1_games_r    <= 4'd0;
            p2_games_r    <= 4'd0;
            game_over_r   <= 1'b0;
            winner_r      <= 1'b0;
            refresh_cnt_r <= '0;
            digit_idx_r   <= 3'd0;
            an_r          <= 8'hFF;
            c_r           <= 7'h7F;
        end else begin
            p1_pts_r      <= p1_pts_nxt_s;
            p2_pts_r      <= p2_pts_nxt_s;
            p1_games_r    <= p1_games_nxt_s;
            p2_games_r    <= p2_games_nxt_s;
            game_over_r   <= game_over_nxt_s;
            winner_r      <= winner_nxt_s;
            refresh_cnt_r <= refresh_cnt_nxt_s;
            digit_idx_r   <= digit_idx_nxt_s;
            an_r          <= an_nxt_s;
            c_r           <= c_nxt_s;
        end
    end

    assign p1_pts    = p1_pts_r;
    assign p2_pts    = p2_pts_r;
    assign p1_games  = p1_games_r;
    assign p2_games  = p2_games_r;
    assign game_over = game_over_r;
    assign winner    = winner_r;
    assign AN        = an_r;
    assign C         = c_r;

endmodule

// File: tb/tb_tennis_scoreboard.sv
// Scoreboard bench: the driver models each cycle in rally-count terms and
// queues the expected outputs; a monitor pops and compares after every edge.
module tb_tennis_scoreboard;

    localparam int RDIV = 4;
    localparam int GW   = 2;

    logic       clk;
    logic       reset_clk;
    logic       point_p1, point_p2;
    logic [7:0] AN;
    logic [6:0] C;
    logic [2:0] p1_pts, p2_pts;
    logic [3:0] p1_games, p2_games;
    logic       game_over, winner;

    tennis_scoreboard #(.REFRESH_DIV(RDIV), .GAMES_TO_WIN(GW)) dut (
        .clk(clk), .reset_clk(reset_clk), .point_p1(point_p1), .point_p2(point_p2),
        .AN(AN), .C(C), .p1_pts(p1_pts), .p2_pts(p2_pts),
        .p1_games(p1_games), .p2_games(p2_games), .game_over(game_over), .winner(winner)
    );

    typedef struct packed {
        logic [2:0] p1;
        logic [2:0] p2;
        logic [3:0] g1;
        logic [3:0] g2;
        logic       over;
        logic       win;
        logic [7:0] an;
        logic [6:0] c;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: raw rallies won in the current game, games, match flags.
    int m_a = 0, m_b = 0, m_g1 = 0, m_g2 = 0, m_over = 0, m_win = 0, scan_cyc = 0;

    logic [6:0] digit_seg [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                  7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pts_code(input int me, input int opp);
        if (me >= 3 && opp >= 3) return (me > opp) ? 4 : 3;
        return me;
    endfunction

    function automatic logic [6:0] tens_seg(input int code);
        case (code)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h30;
            3: return 7'h19;
            4: return 7'h08;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [6:0] units_seg(input int code);
        case (code)
            0, 2, 3: return 7'h40;
            1: return 7'h12;
            4: return 7'h21;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [6:0] model_seg(input int idx);
        case (idx)
            7: return tens_seg(pts_code(m_a, m_b));
            6: return units_seg(pts_code(m_a, m_b));
            4: return digit_seg[m_g1];
            3: return digit_seg[m_g2];
            1: return tens_seg(pts_code(m_b, m_a));
            0: return units_seg(pts_code(m_b, m_a));
            default: return 7'h7F;
        endcase
    endfunction

    task automatic tick(input logic a, input logic b, input logic r);
        exp_t e;
        int   idx;
        @(posedge clk);
        #2;
        point_p1  = a;
        point_p2  = b;
        reset_clk = r;
        if (r) begin
            e.an = 8'hFF;
            e.c  = 7'h7F;
            m_a = 0; m_b = 0; m_g1 = 0; m_g2 = 0; m_over = 0; m_win = 0; scan_cyc = 0;
        end else begin
            scan_cyc = scan_cyc + 1;
            idx  = ((scan_cyc - 1) / RDIV) % 8;
            e.an = ~(8'(1) << idx);
            e.c  = model_seg(idx);
            if ((a ^ b) && m_over == 0) begin
                if (a) m_a++; else m_b++;
                if (m_a >= 4 && m_a - m_b >= 2) begin
                    m_g1++; m_a = 0; m_b = 0;
                    if (m_g1 == GW) begin m_over = 1; m_win = 0; end
                end else if (m_b >= 4 && m_b - m_a >= 2) begin
                    m_g2++; m_a = 0; m_b = 0;
                    if (m_g2 == GW) begin m_over = 1; m_win = 1; end
                end
            end
        end
        e.p1   = 3'(pts_code(m_a, m_b));
        e.p2   = 3'(pts_code(m_b, m_a));
        e.g1   = 4'(m_g1);
        e.g2   = 4'(m_g2);
        e.over = 1'(m_over);
        e.win  = 1'(m_win);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0);
    endtask

    task automatic pt(input int who, input int n);
        for (int i = 0; i < n; i++) begin
            if (who == 1) tick(1'b1, 1'b0, 1'b0);
            else tick(1'b0, 1'b1, 1'b0);
        end
    endtask

    // Monitor: compare every registered output shortly after each active edge.
    initial begin
        exp_t e, act;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {p1_pts, p2_pts, p1_games, p2_games, game_over, winner, AN, C};
                vectors++;
                if (act !== e) begin
                    miscompares++;
                    $display("FAIL outputs t=%0t got pts=%0d/%0d games=%0d/%0d over=%0b win=%0b AN=%h C=%h, exp pts=%0d/%0d games=%0d/%0d over=%0b win=%0b AN=%h C=%h",
                             $time, act.p1, act.p2, act.g1, act.g2, act.over, act.win, act.an, act.c,
                             e.p1, e.p2, e.g1, e.g2, e.over, e.win, e.an, e.c);
                end
            end
        end
    end

    initial begin
        int r;
        reset_clk = 1'b1;
        point_p1  = 1'b0;
        point_p2  = 1'b0;
        repeat (3) tick(1'b0, 1'b0, 1'b1);
        idle(34);
        pt(1, 3); idle(34);
        pt(1, 1); idle(3);
        // Deuce / advantage sequence from a fresh match.
        tick(1'b0, 1'b0, 1'b1);
        pt(1, 3); pt(2, 3);
        pt(1, 1); idle(34);
        pt(2, 1); idle(2);
        tick(1'b1, 1'b1, 1'b0);
        pt(1, 2); idle(2);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b0);
        pt(1, 3); pt(2, 3);
        tick(1'b1, 1'b1, 1'b0);
        pt(2, 2);
        pt(2, 4); idle(2);
        pt(1, 3); pt(2, 2); tick(1'b1, 1'b1, 1'b0); idle(2);
        tick(1'b0, 1'b0, 1'b1); idle(5);
        // Mid-scan reset at 30-15 with one game to P1.
        pt(1, 4); pt(1, 2); pt(2, 1); idle(7);
        tick(1'b0, 1'b0, 1'b1); idle(10);
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2)       tick(1'b0, 1'b0, 1'b1);
            else if (r < 37) tick(1'b1, 1'b0, 1'b0);
            else if (r < 72) tick(1'b0, 1'b1, 1'b0);
            else if (r < 77) tick(1'b1, 1'b1, 1'b0);
            else             tick(1'b0, 1'b0, 1'b0);
        end
        repeat (3) @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain got %0d pending entries, exp 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tennis_scoreboard.md
Name: tennis_scoreboard

Overview:
- Downstream consumer of the ball-movement stage.
- Takes single-cycle point-won pulses for each player and runs tennis game scoring: 0/15/30/40, deuce, advantage, then games.
- Counts games to a match win.
- Time-multiplexes the score onto the 8-digit seven-segment display (AN/C), replacing direct display driving in the movement block.

Parameters:
- REFRESH_DIV, 100000, clock cycles each digit stays lit (1 ms at 100 MHz); must be >= 2.
- GAMES_TO_WIN, 6, games needed to win the match; range 1..9.

Ports:
- clk  input  1  system clock
- reset_clk  input  1  synchronous active-high reset
- point_p1  input  1  one-cycle pulse: player 1 won the rally
- point_p2  input  1  one-cycle pulse: player 2 won the rally
- AN  output  8  digit enables, active low, one-hot-low
- C  output  7  segments, active low; C[0]=a … C[6]=g
- p1_pts  output  3  P1 point code: 0=0, 1=15, 2=30, 3=40, 4=AD
- p2_pts  output  3  P2 point code, same encoding
- p1_games  output  4  P1 games won
- p2_games  output  4  P2 games won
- game_over  output  1  match finished
- winner  output  1  0 = P1, 1 = P2; valid only when game_over=1

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset_clk). All state is registered.
- Reset values: pts=0, games=0, game_over=0, winner=0, AN=8'hFF, C=7'h7F, refresh counter=0, digit index=0.
- Scoring (event = exactly one of point_p1/point_p2 high, and game_over=0). Stated for a P1 point; P2 is symmetric:
  - p1<3: p1 increments.
  - p1=3 and p2<3: P1 wins the game.
  - p1=3 and p2=3: p1 becomes 4 (AD).
  - p1=4: P1 wins the game.
  - p2=4: p2 returns to 3 (deuce, both at 40).
- Game win:
  - Winner's game count increments and both pts clear to 0, all in the same clock edge.
  - If the new count equals GAMES_TO_WIN, set game_over=1 and winner in that same edge.
- Latency: registered outputs reflect an event one cycle after the pulse is sampled.
- Ignored inputs:
  - Both pulses high in the same cycle: no state change.
  - Any pulse while game_over=1: no state change. game_over holds until reset.
- A pulse held high for N cycles counts as N events; upstream guarantees single-cycle pulses.
- Display scan:
  - Refresh counter runs 0..REFRESH_DIV-1. On wrap, the 3-bit digit index increments, wrapping 7→0.
  - AN and C are registered from the digit index and current score. AN[i]=0 only for index i.
  - The first post-reset cycle loads index 0: AN=8'hFE.
  - A displayed value is at most one scan slot stale.
- Digit map:
  - AN7/AN6: P1 points as tens/units: "0 0", "1 5", "3 0", "4 0", "A d".
  - AN5: blank.
  - AN4: P1 games.
  - AN3: P2 games.
  - AN2: blank.
  - AN1/AN0: P2 points, same format as P1.
- Segment codes (hex, active low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10
  - A=08, d=21, blank=7F
- Reset mid-scan or mid-game: on the next edge all state returns to its reset values; no partial update survives.

Test Plan:
- Bench parameters: REFRESH_DIV=4, GAMES_TO_WIN=2.
- Reset held 3 cycles → AN=FF, C=7F, all scores 0. Release → AN=FE for 4 cycles, then FD, FB, … 7F, then FE again; digit 0 shows C=40.
- Three point_p1 pulses → p1_pts=3. When AN=7F, C=19 ("4"); when AN=BF, C=40. Fourth pulse → p1_games=1, p1_pts=0, p2_pts=0 one cycle later.
- Reach 3–3 (deuce). P1 pulse → p1_pts=4; AN7 shows 08, AN6 shows 21. P2 pulse → both pts=3. Two P1 pulses → p1_games increments.
- point_p1 and point_p2 high in the same cycle, at both 0–0 and 3–3 → no score change.
- P2 wins two games → game_over=1 and winner=1 on the cycle the second game completes. Further pulses → no change. reset_clk → all scores clear and game_over=0.
- Assert reset_clk at score 2–1 with p1_games=1 mid-scan → next cycle all state is 0 and AN=FF. After release, scan restarts at AN=FE.
